decimal_counter_7seg: RTL and testbench

Parametrised multi-digit BCD counter with built-in tick prescaler and per-digit seven-segment decode for the DE10-Standard HEX displays. Counts up or down at a rate derived from the board clock and supports clear and parallel load. It drives HEX0..HEX(DIGITS-1) directly and exports the BCD value and wrap status to neighbouring lab logic.

---
 rtl/decimal_counter_7seg.sv | 144 ++++++++++++++
 tb/tb_decimal_counter_7seg.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/decimal_counter_7seg.sv
// Multi-digit BCD up/down counter with tick prescaler and 7-seg decode.
// Ports: clk, rst (sync, active-high), en, up, clear, load, load_val[4*DIGITS]
//        -> bcd[4*DIGITS], hex[7*DIGITS] (active-low {g..a}), tick, wrap.
module decimal_counter_7seg #(
  parameter int DIGITS  = 2,
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  tick,
  output logic                  wrap
);

  localparam int DIV = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [PW-1:0]       pre_q;
  logic [PW-1:0]       pre_n;
  logic [4*DIGITS-1:0] bcd_n;
  logic [4*DIGITS-1:0] inc_v;
  logic [4*DIGITS-1:0] dec_v;
  logic [4*DIGITS-1:0] sat_v;
  logic [7*DIGITS-1:0] hex_n;
  logic                inc_c;
  logic                dec_b;
  logic                step;
  logic                tick_n;
  logic                wrap_n;

  assign step = en && (pre_q == LAST);

  // Ripple carry/borrow across digits; a carry or borrow that
  // survives past the top digit is exactly the wrap condition.
  always_comb begin
    inc_v = bcd;
    dec_v = bcd;
    inc_c = 1'b1;
    dec_b = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (inc_c) begin
        if (bcd[4*k +: 4] >= 4'd9) begin
          inc_v[4*k +: 4] = 4'd0;
        end else begin
          inc_v[4*k +: 4] = bcd[4*k +: 4] + 4'd1;
          inc_c = 1'b0;
        end
      end
      if (dec_b) begin
        if (bcd[4*k +: 4] == 4'd0) begin
          dec_v[4*k +: 4] = 4'd9;
        end else begin
          dec_v[4*k +: 4] = bcd[4*k +: 4] - 4'd1;
          dec_b = 1'b0;
        end
      end
    end
  end

  // Out-of-range load nibbles saturate to 9 so the count stays BCD.
  always_comb begin
    sat_v = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (load_val[4*k +: 4] > 4'd9) begin
        sat_v[4*k +: 4] = 4'd9;
      end else begin
        sat_v[4*k +: 4] = load_val[4*k +: 4];
      end
    end
  end

  always_comb begin
    pre_n  = pre_q;
    bcd_n  = bcd;
    tick_n = 1'b0;
    wrap_n = 1'b0;
    if (en) begin
      pre_n = step ? '0 : pre_q + PW'(1);
    end
    if (clear) begin
      pre_n = '0;
      bcd_n = '0;
    end else if (load) begin
      pre_n = '0;
      bcd_n = sat_v;
    end else if (step) begin
      tick_n = 1'b1;
      bcd_n  = up ? inc_v : dec_v;
      wrap_n = up ? inc_c : dec_b;
    end
  end

  // Decode the next value so hex and bcd move on the same edge.
  always_comb begin
    hex_n = '0;
    for (int k = 0; k < DIGITS; k++) begin
      hex_n[7*k +: 7] = seg(bcd_n[4*k +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      bcd   <= '0;
      hex   <= {DIGITS{SEG_ZERO}};
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      pre_q <= pre_n;
      bcd   <= bcd_n;
      hex   <= hex_n;
      tick  <= tick_n;
      wrap  <= wrap_n;
    end
  end

endmodule

// File: tb/tb_decimal_counter_7seg.sv
// Scoreboard bench: 2-digit and 1-digit counters (DIV=4) share stimulus
// and are compared each cycle against an integer-valued reference model.
module tb_decimal_counter_7seg;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst, en, up, clear, load;
  logic [7:0] load_val;
  logic [7:0] bcd2;
  logic [13:0] hex2;
  logic       tick2, wrap2;
  logic [3:0] bcd1;
  logic [6:0] hex1;
  logic       tick1, wrap1;

  always #5 clk = ~clk;

  decimal_counter_7seg #(.DIGITS(2), .CLK_HZ(4), .TICK_HZ(1)) dut2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear),
    .load(load), .load_val(load_val), .bcd(bcd2), .hex(hex2),
    .tick(tick2), .wrap(wrap2)
  );

  decimal_counter_7seg #(.DIGITS(1), .CLK_HZ(4), .TICK_HZ(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear),
    .load(load), .load_val(load_val[3:0]), .bcd(bcd1), .hex(hex1),
    .tick(tick1), .wrap(wrap1)
  );

  typedef struct {
    logic [7:0]  bcd2;
    logic [13:0] hex2;
    logic        tick2;
    logic        wrap2;
    logic [3:0]  bcd1;
    logic [6:0]  hex1;
    logic        tick1;
    logic        wrap1;
  } exp_t;

  exp_t exq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [6:0] segtab [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  int v2 = 0;
  int v1 = 0;
  int pre = 0;

  function automatic int pow10(input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic void nxt(input int d, input int v, input bit r,
                              input bit c, input bit l, input bit s,
                              input bit u, input logic [7:0] lv,
                              output int nv, output bit tk,
                              output bit wr);
    int mx = pow10(d) - 1;
    logic [7:0] lvv = lv;
    nv = v;
    tk = 0;
    wr = 0;
    if (r || c) begin
      nv = 0;
    end else if (l) begin
      nv = 0;
      for (int k = 0; k < d; k++) begin
        int dg = int'(lvv[4*k +: 4]);
        if (dg > 9) dg = 9;
        nv = nv + dg * pow10(k);
      end
    end else if (s) begin
      tk = 1;
      if (u) begin
        wr = (v == mx);
        nv = wr ? 0 : v + 1;
      end else begin
        wr = (v == 0);
        nv = wr ? mx : v - 1;
      end
    end
  endfunction

  function automatic logic [7:0] tobcd(input int v);
    logic [7:0] b;
    b[3:0] = 4'((v) % 10);
    b[7:4] = 4'((v / 10) % 10);
    return b;
  endfunction

  task automatic cyc(input bit r, input bit c, input bit l,
                     input bit e, input bit u, input logic [7:0] lv);
    exp_t x;
    bit   s, t2, w2, t1, w1;
    int   n2, n1;
    logic [7:0] b;
    rst = r; clear = c; load = l; en = e; up = u; load_val = lv;
    s = !r && e && (pre == DIV - 1);
    nxt(2, v2, r, c, l, s, u, lv, n2, t2, w2);
    nxt(1, v1, r, c, l, s, u, lv, n1, t1, w1);
    if (r || c || l) pre = 0;
    else if (e) pre = s ? 0 : pre + 1;
    v2 = n2;
    v1 = n1;
    b = tobcd(v2);
    x.bcd2  = b;
    x.hex2  = {segtab[v2 / 10], segtab[v2 % 10]};
    x.tick2 = t2 && !r && !c && !l;
    x.wrap2 = w2 && !r && !c && !l;
    x.bcd1  = 4'(v1);
    x.hex1  = segtab[v1];
    x.tick1 = t1 && !r && !c && !l;
    x.wrap1 = w1 && !r && !c && !l;
    exq.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exq.size() > 0) begin
      exp_t x;
      x = exq.pop_front();
      chk("bcd2", int'(bcd2), int'(x.bcd2));
      chk("hex2", int'(hex2), int'(x.hex2));
      chk("tick2", int'(tick2), int'(x.tick2));
      chk("wrap2", int'(wrap2), int'(x.wrap2));
      chk("bcd1", int'(bcd1), int'(x.bcd1));
      chk("hex1", int'(hex1), int'(x.hex1));
      chk("tick1", int'(tick1), int'(x.tick1));
      chk("wrap1", int'(wrap1), int'(x.wrap1));
    end
  end

  initial begin
    bit u;
    rst = 1; en = 0; up = 1; clear = 0; load = 0; load_val = '0;
    #1;
    // reset, then count up through a few steps
    repeat (2) cyc(1, 0, 0, 0, 1, 8'h00);
    repeat (13) cyc(0, 0, 0, 1, 1, 8'h00);
    // load 98 and roll over 99 -> 00
    cyc(0, 0, 1, 1, 1, 8'h98);
    repeat (12) cyc(0, 0, 0, 1, 1, 8'h00);
    // load 00, count down through 00 -> 99 -> 98
    cyc(0, 0, 1, 1, 0, 8'h00);
    repeat (10) cyc(0, 0, 0, 1, 0, 8'h00);
    // saturating load, clear beats load
    cyc(0, 0, 1, 0, 1, 8'hAF);
    cyc(0, 1, 1, 1, 1, 8'h55);
    // load landing on a step cycle
    repeat (3) cyc(0, 0, 0, 1, 1, 8'h00);
    cyc(0, 0, 1, 1, 1, 8'h42);
    // freeze mid-prescale, then resume
    repeat (2) cyc(0, 0, 0, 1, 1, 8'h00);
    repeat (10) cyc(0, 0, 0, 0, 1, 8'h00);
    repeat (6) cyc(0, 0, 0, 1, 1, 8'h00);
    // reset on the cycle a step is due
    while (pre != DIV - 1) cyc(0, 0, 0, 1, 1, 8'h00);
    cyc(1, 0, 0, 1, 1, 8'h00);
    repeat (2) cyc(0, 0, 0, 1, 1, 8'h00);
    // randomized traffic
    u = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) u = ~u;
      cyc($urandom_range(0, 299) == 0,
          $urandom_range(0, 99) == 0,
          $urandom_range(0, 59) == 0,
          $urandom_range(0, 9) < 8,
          u, 8'($urandom));
    end
    cyc(0, 0, 0, 0, 1, 8'h00);
    @(negedge clk);
    #1;
    chk("drain", exq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
